// File: rtl/cc1200_spi_sequencer.sv
// CC1200 SPI command sequencer: queues command words and plays them to the SPI engine one at a time.
// Optional macro CC1200_SEQ_TIMEOUT_EN adds busy-rise/busy-fall timeouts and the rsp_err flag.

module cc1200_spi_sequencer #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int BUSY_WAIT = 16,
    parameter int DONE_WAIT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_wr,
    input  logic        cmd_read,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        spi_start,
    input  logic        spi_busy,
    output logic [31:0] spi_data_out,
    output logic [3:0]  spi_wr,
    input  logic [31:0] spi_data_in,
    output logic [AW:0] fifo_level,
    output logic        idle
);

    generate
        if (DEPTH < 2 || DEPTH != (1 << AW) || BUSY_WAIT < 1 || DONE_WAIT < 1) begin : g_param_check
            $error("cc1200_spi_sequencer: DEPTH must be 2**AW (>=2) and wait limits >= 1");
        end
    endgenerate

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t state;

    logic [31:0]   fifo_data [DEPTH];
    logic [3:0]    fifo_wr   [DEPTH];
    logic          fifo_rd   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          push, pop;
    logic          hold_read;
    logic          tmo;

    assign cmd_ready  = (level != FULL);
    assign push       = cmd_valid && cmd_ready;
    // Pop only from IDLE, so RESP naturally blocks the next command.
    assign pop        = (state == S_IDLE) && (level != '0);
    assign fifo_level = level;
    assign idle       = (level == '0) && (state == S_IDLE);

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= cmd_data;
            fifo_wr[wr_ptr]   <= cmd_wr;
            fifo_rd[wr_ptr]   <= cmd_read;
        end
    end

`ifdef CC1200_SEQ_TIMEOUT_EN
    localparam int CMAX = (BUSY_WAIT > DONE_WAIT) ? BUSY_WAIT : DONE_WAIT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_WAIT - 1);
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_WAIT - 1);

    logic [CW-1:0] cnt;
    logic          err_sticky;
    logic          rsp_err_q;

    assign rsp_err = rsp_err_q;
    assign tmo = ((state == S_WAIT_BUSY) && !spi_busy && (cnt == BUSY_LAST)) ||
                 ((state == S_WAIT_DONE) &&  spi_busy && (cnt == DONE_LAST));
`else
    assign rsp_err = 1'b0;
    assign tmo     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            spi_start    <= 1'b0;
            spi_data_out <= '0;
            spi_wr       <= '0;
            hold_read    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
`ifdef CC1200_SEQ_TIMEOUT_EN
            cnt          <= '0;
            err_sticky   <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            spi_start <= 1'b0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
`ifdef CC1200_SEQ_TIMEOUT_EN
            // Write-only timeouts have nowhere to report; remember them internally.
            err_sticky <= err_sticky | (tmo & ~hold_read);
`endif

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        spi_data_out <= fifo_data[rd_ptr];
                        spi_wr       <= fifo_wr[rd_ptr];
                        hold_read    <= fifo_rd[rd_ptr];
                        spi_start    <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef CC1200_SEQ_TIMEOUT_EN
                    cnt <= '0;
`endif
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (tmo) begin
                        if (hold_read) begin
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
`ifdef CC1200_SEQ_TIMEOUT_EN
                            rsp_err_q <= 1'b1;
`endif
                            state     <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (state == S_WAIT_BUSY && spi_busy) begin
`ifdef CC1200_SEQ_TIMEOUT_EN
                        cnt <= '0;
`endif
                        state <= S_WAIT_DONE;
                    end else if (state == S_WAIT_DONE && !spi_busy) begin
                        state <= S_CAPTURE;
                    end else begin
`ifdef CC1200_SEQ_TIMEOUT_EN
                        if (cnt != '1) cnt <= cnt + CW'(1);
`endif
                    end
                end
                S_CAPTURE: begin
                    if (hold_read) begin
                        rsp_data  <= spi_data_in;
                        rsp_valid <= 1'b1;
`ifdef CC1200_SEQ_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= S_RESP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
